// File: rtl/serial_bit_tx.sv
// serial_bit_tx: parallel-in, serial-out bit launcher.
// Accepts a word on a valid/ready handshake and sends it MSB-first, one bit per clk,
// with a frame strobe and last-bit flag, followed by a fixed inter-frame gap.
module serial_bit_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned IDLE_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_data,
  output logic             ser_frame,
  output logic             ser_last,
  output logic             busy
);

  // Bit counter spans 0..WIDTH-1, gap counter spans 0..IDLE_BITS-1; both at least 1 bit.
  localparam int unsigned CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W    = (IDLE_BITS > 2) ? $clog2(IDLE_BITS) : 1;
  localparam int unsigned GAP_LAST = (IDLE_BITS > 0) ? IDLE_BITS - 1 : 0;
  // The MSB goes straight to the line on accept, so only the remaining bits are held.
  localparam int unsigned SH_W     = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  logic [SH_W-1:0]   r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_ser_data;
  logic              r_ser_frame;
  logic              r_ser_last;
  logic              r_busy;

  logic              w_accept;
  logic              w_bit_end;
  logic              w_gap_end;

  assign w_accept  = tx_valid && (r_state == S_IDLE);
  assign w_bit_end = (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_gap_end = (r_gap_cnt == GAP_W'(GAP_LAST));

  // Ready depends on state only so upstream never sees a valid-to-ready loop.
  assign tx_ready  = (r_state == S_IDLE);
  assign ser_data  = r_ser_data;
  assign ser_frame = r_ser_frame;
  assign ser_last  = r_ser_last;
  assign busy      = r_busy;

  // Frame sequencer: load on accept, walk bits MSB to LSB, then hold the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_ser_data  <= 1'b0;
      r_ser_frame <= 1'b0;
      r_ser_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_SHIFT;
            r_shift     <= tx_data[SH_W-1:0];
            r_ser_data  <= tx_data[WIDTH-1];
            r_ser_frame <= 1'b1;
            r_ser_last  <= 1'b0;
            r_bit_cnt   <= '0;
            r_busy      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_bit_end) begin
            r_ser_data  <= 1'b0;
            r_ser_frame <= 1'b0;
            r_ser_last  <= 1'b0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            if (IDLE_BITS > 0) begin
              r_state <= S_GAP;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_ser_data <= r_shift[SH_W-1];
            r_shift    <= r_shift << 1;
            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
            r_ser_last <= (r_bit_cnt == CNT_W'(WIDTH - 2));
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_ser_data  <= 1'b0;
          r_ser_frame <= 1'b0;
          r_ser_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
